axis_dot_acc: RTL and testbench

- Downstream consumer of the vedic8x8 multiplier stage in the axis_mul matrix-multiply path.
- Accepts a stream of unsigned 16-bit products over an AXI-Stream slave.
- Accumulates DOT_LEN products, or fewer if ended early by tlast, into one dot-product result (one matrix element).
- Emits each result on an AXI-Stream master with a one-entry output register and backpressure; asserts m_axis_tlast on the last element of each output row.

---
 rtl/axis_mul_pkg.sv | 39 +++
 rtl/axis_out_reg.sv | 51 +++++
 rtl/axis_dot_acc.sv | 119 +++++++++++
 tb/tb_axis_dot_acc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_mul_pkg.sv
// Shared types and helpers for the axis_mul matrix-multiply path.
// AXIS_DOT_SAT_EN (used by axis_dot_acc) selects saturating instead of wrapping accumulation.
package axis_mul_pkg;

    localparam int unsigned PROD_W_DEFAULT = 16;
    // Widest accumulator the add helper supports.
    localparam int unsigned ACC_MAX_W      = 32;

    typedef enum logic [0:0] {
        ST_ACC,
        ST_HOLD
    } dot_state_e;

    typedef struct packed {
        logic                 ovf;
        logic [ACC_MAX_W-1:0] sum;
    } acc_add_t;

    // Adds two values already below 2^acc_w. Any carry past bit acc_w-1 flags overflow;
    // the result then either clamps to 2^acc_w-1 (sat) or wraps modulo 2^acc_w.
    function automatic acc_add_t acc_add(input logic [ACC_MAX_W-1:0] a,
                                         input logic [ACC_MAX_W-1:0] b,
                                         input int unsigned          acc_w,
                                         input logic                 sat);
        logic [ACC_MAX_W:0] wide;
        logic [ACC_MAX_W:0] mask;
        acc_add_t           res;
        wide    = {1'b0, a} + {1'b0, b};
        mask    = ({{ACC_MAX_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
        res.ovf = |(wide & ~mask);
        if (res.ovf) begin
            res.sum = sat ? mask[ACC_MAX_W-1:0] : wide[ACC_MAX_W-1:0] & mask[ACC_MAX_W-1:0];
        end else begin
            res.sum = wide[ACC_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: data/last hold while stalled, reload on drain.
module axis_out_reg #(
    parameter int unsigned DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    // A load always wins; otherwise a handshake empties the entry.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            last_d  = load_last;
            valid_d = 1'b1;
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: rtl/axis_dot_acc.sv
// Dot-product accumulator on an AXI-Stream of unsigned products.
// Define AXIS_DOT_SAT_EN to clamp on overflow instead of wrapping.
module axis_dot_acc
    import axis_mul_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEFAULT,
    parameter int unsigned DOT_LEN = 8,
    parameter int unsigned ACC_W   = 19,
    parameter int unsigned ROW_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [ACC_W-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              ovf
);

    localparam int unsigned CntW = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    localparam int unsigned RowW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
`ifdef AXIS_DOT_SAT_EN
    localparam logic SatEn = 1'b1;
`else
    localparam logic SatEn = 1'b0;
`endif

    dot_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CntW-1:0] term_cnt_q, term_cnt_d;
    logic [RowW-1:0] row_cnt_q, row_cnt_d;
    logic            ovf_q, ovf_d;

    logic            beat_final;
    logic            accept;
    logic            load;
    logic            row_last;
    logic            spare;
    logic            add_ovf;
    acc_add_t        add_res;
    logic [ACC_W-1:0] sum;

    assign add_res = acc_add(ACC_MAX_W'(acc_q), ACC_MAX_W'(s_axis_tdata), ACC_W, SatEn);
    assign sum     = add_res.sum[ACC_W-1:0];

    // Bits above ACC_W are always zero; folded in so the whole helper result is consumed.
    if (ACC_W < ACC_MAX_W) begin : g_spare
        assign spare = |add_res.sum[ACC_MAX_W-1:ACC_W];
    end else begin : g_no_spare
        assign spare = 1'b0;
    end
    assign add_ovf = add_res.ovf | spare;

    assign beat_final = (term_cnt_q == CntW'(DOT_LEN - 1)) || s_axis_tlast;
    assign row_last   = (row_cnt_q == RowW'(ROW_LEN - 1));

    // Only a final beat needs the output slot, so non-final beats keep flowing while a
    // result is stalled. Nothing here depends on s_axis_tvalid.
    assign s_axis_tready = (state_q == ST_ACC) || m_axis_tready || !beat_final;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign load          = accept && beat_final;

    // Accumulate, count terms/results, and track output-slot occupancy as the FSM state.
    always_comb begin
        acc_d      = acc_q;
        term_cnt_d = term_cnt_q;
        row_cnt_d  = row_cnt_q;
        ovf_d      = ovf_q | (accept & add_ovf);
        state_d    = (load || ((state_q == ST_HOLD) && !m_axis_tready)) ? ST_HOLD : ST_ACC;
        if (accept) begin
            if (beat_final) begin
                acc_d      = '0;
                term_cnt_d = '0;
                row_cnt_d  = row_last ? '0 : row_cnt_q + 1'b1;
            end else begin
                acc_d      = sum;
                term_cnt_d = term_cnt_q + 1'b1;
            end
        end
    end

    // Accumulator and control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            term_cnt_q <= '0;
            row_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            term_cnt_q <= term_cnt_d;
            row_cnt_q  <= row_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    axis_out_reg #(
        .DATA_W(ACC_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_data    (sum),
        .load_last    (row_last),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_dot_acc.sv
// Directed bench for axis_dot_acc: default instance plus an ACC_W=17 instance for overflow.
module tb_axis_dot_acc;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [18:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast, ovf;

    logic [15:0] b_tdata;
    logic        b_tvalid, b_tready, b_tlast;
    logic [16:0] bm_tdata;
    logic        bm_tvalid, bm_tready, bm_tlast, b_ovf;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned res_idx = 0;

    always #5 clk = ~clk;

    axis_dot_acc u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .ovf          (ovf)
    );

    axis_dot_acc #(
        .ACC_W(17)
    ) u_dut17 (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (b_tdata),
        .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready),
        .s_axis_tlast (b_tlast),
        .m_axis_tdata (bm_tdata),
        .m_axis_tvalid(bm_tvalid),
        .m_axis_tready(bm_tready),
        .m_axis_tlast (bm_tlast),
        .ovf          (b_ovf)
    );

    typedef struct {
        int unsigned n;
        logic [15:0] base;
        logic [15:0] step;
        logic        tlast_end;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Offer one beat to the default instance and wait for the handshake edge.
    task automatic send_beat(input logic [15:0] d, input logic l);
        @(negedge clk);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        chk("s_tready", 32'(s_tready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{n: 8, base: 16'h7D94, step: 16'd0, tlast_end: 1'b0, exp: 19'h3ECA0};
        vecs[1] = '{n: 8, base: 16'hFE01, step: 16'd0, tlast_end: 1'b0, exp: 19'h7F008};
        vecs[2] = '{n: 3, base: 16'd1,    step: 16'd1, tlast_end: 1'b1, exp: 19'd6};
        vecs[3] = '{n: 8, base: 16'd1,    step: 16'd0, tlast_end: 1'b0, exp: 19'd8};
        vecs[4] = '{n: 1, base: 16'h1234, step: 16'd0, tlast_end: 1'b1, exp: 19'h1234};
        vecs[5] = '{n: 8, base: 16'd2,    step: 16'd0, tlast_end: 1'b1, exp: 19'd16};
        vecs[6] = '{n: 8, base: 16'd1,    step: 16'd1, tlast_end: 1'b0, exp: 19'd36};

        rst_n    = 1'b0;
        s_tdata  = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        b_tdata  = '0; b_tvalid = 1'b0; b_tlast = 1'b0; bm_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst m_tdata", 32'(m_tdata), 32'd0);
        chk("rst m_tlast", 32'(m_tlast), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst s_tready", 32'(s_tready), 32'd1);
        rst_n = 1'b1;

        // Table: each record is one dot product drained immediately.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                send_beat(vecs[v].base + 16'(i) * vecs[v].step,
                          vecs[v].tlast_end && (i == int'(vecs[v].n) - 1));
            end
            idle_in();
            chk($sformatf("vec%0d valid", v), 32'(m_tvalid), 32'd1);
            chk($sformatf("vec%0d data", v), 32'(m_tdata), 32'(vecs[v].exp));
            chk($sformatf("vec%0d tlast", v), 32'(m_tlast), 32'((res_idx % 8) == 7));
            res_idx++;
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d single", v), 32'(m_tvalid), 32'd0);
        end
        chk("ovf after max", 32'(ovf), 32'd0);

        // Backpressure: result held, non-final beats still accepted, final beat stalls.
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(16'd1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send_beat(16'd2, 1'b0);
            chk("bp hold data", 32'(m_tdata), 32'd8);
        end
        @(negedge clk);
        s_tdata = 16'd2; s_tlast = 1'b0; s_tvalid = 1'b1;
        #1;
        chk("bp stall ready", 32'(s_tready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp stall ready", 32'(s_tready), 32'd0);
            chk("bp stall valid", 32'(m_tvalid), 32'd1);
            chk("bp stall data", 32'(m_tdata), 32'd8);
            chk("bp stall tlast", 32'(m_tlast), 32'((res_idx % 8) == 7));
        end
        res_idx++;
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        chk("bp drain ready", 32'(s_tready), 32'd1);
        @(posedge clk);
        idle_in();
        chk("bp second valid", 32'(m_tvalid), 32'd1);
        chk("bp second data", 32'(m_tdata), 32'd16);
        chk("bp second tlast", 32'(m_tlast), 32'((res_idx % 8) == 7));
        res_idx++;
        @(negedge clk);
        #1;
        chk("bp drained", 32'(m_tvalid), 32'd0);

        // Reset with a pending output and a partial accumulation.
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(16'd3, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(16'd5, 1'b0);
        idle_in();
        chk("pre-rst valid", 32'(m_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst valid", 32'(m_tvalid), 32'd0);
        chk("mid-rst data", 32'(m_tdata), 32'd0);
        chk("mid-rst tlast", 32'(m_tlast), 32'd0);
        chk("mid-rst ovf", 32'(ovf), 32'd0);
        res_idx = 0;
        @(negedge clk);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(16'd1, 1'b0);
        idle_in();
        chk("post-rst valid", 32'(m_tvalid), 32'd1);
        chk("post-rst data", 32'(m_tdata), 32'd8);
        chk("post-rst tlast", 32'(m_tlast), 32'd0);

        // Overflow on the 17-bit instance.
        chk("acc17 ovf before", 32'(b_ovf), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_tdata = 16'hFE01; b_tlast = (i == 2); b_tvalid = 1'b1;
            #1;
            chk("acc17 s_tready", 32'(b_tready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        b_tvalid = 1'b0; b_tlast = 1'b0;
        #1;
        chk("acc17 valid", 32'(bm_tvalid), 32'd1);
`ifdef AXIS_DOT_SAT_EN
        chk("acc17 data", 32'(bm_tdata), 32'h1FFFF);
`else
        chk("acc17 data", 32'(bm_tdata), 32'hFA03);
`endif
        chk("acc17 ovf", 32'(b_ovf), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("acc17 ovf sticky", 32'(b_ovf), 32'd1);
        chk("default ovf clear", 32'(ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
